// File: rtl/stream_serializer.sv
// Width-down serializer: accepts one OutWidth*Ratio word per handshake and
// emits it as Ratio beats of OutWidth bits, flagging the final beat with last_o.
module stream_serializer #(
  parameter int unsigned OutWidth = 8,
  parameter int unsigned Ratio    = 4,
  parameter bit          MsbFirst = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [OutWidth*Ratio-1:0] data_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [OutWidth-1:0]       data_o,
  output logic                      last_o
);

  localparam int unsigned InWidth = OutWidth * Ratio;
  localparam int unsigned CntW    = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(Ratio - 1);

  typedef enum logic {
    EMPTY       = 1'b0,
    SERIALIZING = 1'b1
  } state_e;

  state_e              r_state;
  logic [CntW-1:0]     r_cnt;
  logic [InWidth-1:0]  r_buf;

  logic                w_last;
  logic                w_in_hs;
  logic                w_out_hs;
  logic [CntW-1:0]     w_idx;
  logic [OutWidth-1:0] w_data;

  assign valid_o  = (r_state == SERIALIZING);
  assign w_last   = valid_o && (r_cnt == LastIdx);
  assign last_o   = w_last;
  // ready_i -> ready_o is combinational so a new word loads on the last beat.
  assign ready_o  = !valid_o || (w_last && ready_i);
  assign w_in_hs  = valid_i && ready_o;
  assign w_out_hs = valid_o && ready_i;
  assign w_idx    = MsbFirst ? (LastIdx - r_cnt) : r_cnt;

  // Slice select with constant part-selects; w_idx never exceeds Ratio-1.
  always_comb begin
    w_data = '0;
    for (int k = 0; k < int'(Ratio); k++) begin
      if (w_idx == CntW'(k)) begin
        w_data = r_buf[k*OutWidth +: OutWidth];
      end
    end
  end

  assign data_o = w_data;

  // Input handshake wins over the final output handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= EMPTY;
      r_cnt   <= '0;
      r_buf   <= '0;
    end else if (w_in_hs) begin
      r_state <= SERIALIZING;
      r_cnt   <= '0;
      r_buf   <= data_i;
    end else if (w_out_hs) begin
      if (w_last) begin
        r_state <= EMPTY;
        r_cnt   <= '0;
      end else begin
        r_cnt   <= r_cnt + CntW'(1);
      end
    end
  end

endmodule

// File: doc/stream_serializer.md
# stream_serializer

Single-clock width-down serializer. It accepts one wide word per valid/ready handshake and emits it as `Ratio` narrow beats on a valid/ready output, flagging the final beat. It sits directly upstream of the isochronous spill register, narrowing the payload before the clock-domain handoff so that fewer bits are carried across. Its output handshake obeys the same stability rules that the spill register asserts on its source side.

## Interface
- `OutWidth`, default 8: width of one output beat in bits; must be ≥1.
- `Ratio`, default 4: number of beats per input word; must be ≥1.
- `MsbFirst`, default 1'b0: 0 emits the least-significant slice first; 1 emits the most-significant slice first.
- `clk_i`  in  1  clock; all state is updated on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `valid_i`  in  1  input word valid.
- `ready_o`  out  1  block can accept an input word.
- `data_i`  in  `OutWidth*Ratio`  input word.
- `valid_o`  out  1  output beat valid.
- `ready_i`  in  1  downstream accepts the beat.
- `data_o`  out  `OutWidth`  current beat.
- `last_o`  out  1  current beat is the final slice of its word.

## Operation
- **State**
  - `full_q`: buffer holds a word.
  - `buf_q`: the stored word, `OutWidth*Ratio` bits.
  - `cnt_q`: beat index, `max(1,$clog2(Ratio))` bits, counting 0..`Ratio-1`.
- **States**
  - EMPTY (`full_q`=0) goes to SERIALIZING on an input handshake.
  - SERIALIZING (`full_q`=1) advances `cnt_q` on each output handshake.
  - On the final output handshake the block returns to EMPTY, or stays in SERIALIZING with the new word if an input handshake happens in the same cycle.
- **Output signals**
  - `valid_o = full_q`.
  - `last_o = full_q && (cnt_q == Ratio-1)`.
  - `data_o` is slice `cnt_q` of `buf_q` when `MsbFirst`=0, and slice `Ratio-1-cnt_q` when `MsbFirst`=1. Slice k is bits `[k*OutWidth +: OutWidth]`.
- **Input ready**
  - `ready_o = !full_q || (last_o && ready_i)`.
  - This is a combinational path from `ready_i` to `ready_o`, by design. No path exists from `valid_i` to `valid_o`.
- **Input handshake** (`valid_i && ready_o`)
  - `buf_q <= data_i`, `cnt_q <= 0`, `full_q <= 1`.
- **Output handshake, not last**
  - `cnt_q <= cnt_q + 1`.
- **Output handshake on last beat without input handshake**
  - `full_q <= 0`, `cnt_q <= 0`.
- **Simultaneous last-beat and input handshake**
  - The input handshake takes priority: the new word is loaded with `cnt_q`=0 and `full_q` stays 1.
- **`Ratio`=1**
  - The block degenerates to a one-entry pipeline register with full throughput.
  - `last_o` equals `valid_o`.
- `buf_q` is updated only on an input handshake and holds its value otherwise.

## Timing
- **Reset values:** `valid_o`=0, `last_o`=0, `data_o`=0 (`buf_q` resets to '0), `cnt_q`=0. `ready_o`=1 while held in reset and after release.
- **Reset mid-word:** asserting `rst_ni` low discards the partial word immediately (asynchronous). The next output is only produced after a new input handshake.
- **Latency:** the first beat appears on `valid_o` in the cycle after the input handshake.
- **Throughput:** one beat per cycle while `ready_i`=1. Consecutive words are emitted with no bubble because of the simultaneous last/load rule.
- **Stability:**
  - While `valid_o && !ready_i`, the outputs `valid_o`, `data_o` and `last_o` remain stable.
  - While `!ready_o`, `valid_i` and `data_i` are assumed stable; the bench asserts this.
- **Counter wrap:** `cnt_q` never exceeds `Ratio-1`. When `Ratio` is a power of two it must not wrap through the natural overflow path.

## Test plan
- **Basic serialization:** `OutWidth`=8, `Ratio`=4, `MsbFirst`=0, `ready_i`=1; input `0xDDCCBBAA` → beats `AA`,`BB`,`CC`,`DD` on four consecutive cycles starting one cycle after the handshake. `last_o`=1 only on `DD`. `ready_o`=0 on the `AA`/`BB`/`CC` cycles.
- **Back-to-back words:** inputs `0x44332211` then `0x88776655` with `valid_i` held → 8 contiguous beats `11..88` with no idle cycle. The second handshake occurs in the cycle beat `44` is accepted.
- **Backpressure:** drop `ready_i` for 3 cycles while `BB` is presented → `data_o`=`BB`, `valid_o`=1 and `last_o`=0 all stay stable. The remaining beats follow in order once `ready_i` returns.
- **`MsbFirst`=1:** input `0xDDCCBBAA` → beats `DD`,`CC`,`BB`,`AA`, with `last_o` on `AA`.
- **`Ratio`=1, `OutWidth`=16:** inputs `0x1234` then `0x5678` with `ready_i`=1 → outputs one cycle later with `last_o`=1 on each. Alternating `ready_i` 1/0 does not lose or duplicate either word.
- **Reset mid-word:** assert `rst_ni` low after `BB` is accepted → `valid_o`, `last_o`, `data_o` go to 0 and `ready_o` to 1 immediately. After release, the new input `0x0000EE01` yields beats `01`,`EE`,`00`,`00`.
